// File: rtl/traffic_phase_sequencer_if.sv
// Detector/lamp bundle for the traffic phase sequencer: timing strobe, demand and
// flash request in; lamp drives and phase/state/timer status out.
interface traffic_phase_sequencer_if #(
    parameter int N_PHASES = 4,
    parameter int TIMER_W  = 6,
    parameter int PH_W     = (N_PHASES > 2) ? $clog2(N_PHASES) : 1
);
    logic                tick;
    logic [N_PHASES-1:0] demand;
    logic                flash_en;
    logic [N_PHASES-1:0] green;
    logic [N_PHASES-1:0] yellow;
    logic [N_PHASES-1:0] red;
    logic [PH_W-1:0]     phase_idx;
    logic [1:0]          state;
    logic [TIMER_W-1:0]  timer;

    modport master (
        output tick, demand, flash_en,
        input  green, yellow, red, phase_idx, state, timer
    );

    modport slave (
        input  tick, demand, flash_en,
        output green, yellow, red, phase_idx, state, timer
    );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// N-approach round-robin signal sequencer with demand skipping, rest-in-green and
// flash mode; every interval advances only on the external tick strobe.
module traffic_phase_sequencer #(
    parameter int N_PHASES      = 4,
    parameter int TIMER_W       = 6,
    parameter int GREEN_TIME    = 30,
    parameter int YELLOW_TIME   = 5,
    parameter int ALLRED_TIME   = 2,
    parameter int REST_IN_GREEN = 1,
    localparam int PH_W         = (N_PHASES > 2) ? $clog2(N_PHASES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    traffic_phase_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2,
        S_FLASH  = 2'd3
    } state_t;

    localparam logic [N_PHASES-1:0] ONE_HOT0 = N_PHASES'(1);
    localparam logic [TIMER_W-1:0]  T_GREEN  = TIMER_W'(GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0]  T_YELLOW = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0]  T_ALLRED = TIMER_W'(ALLRED_TIME - 1);

    state_t              state_reg, state_next;
    logic [PH_W-1:0]     phase_reg, phase_next, rr_phase;
    logic [TIMER_W-1:0]  timer_reg, timer_next;
    logic                blink_reg, blink_next;
    logic                from_flash_reg, from_flash_next;
    logic [N_PHASES-1:0] green_reg, green_next;
    logic [N_PHASES-1:0] yellow_reg, yellow_next;
    logic [N_PHASES-1:0] red_reg, red_next;
    logic [N_PHASES-1:0] phase_onehot;
    logic                other_demand;

    for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_onehot
        assign phase_onehot[gi] = (phase_reg == PH_W'(gi));
    end

    assign other_demand = |(bus.demand & ~phase_onehot);

    // Walk candidates from farthest to nearest so the nearest demanding phase wins;
    // falls back to plain successor when nobody else is waiting.
    always_comb begin
        int cand;
        cand     = 0;
        rr_phase = (phase_reg == PH_W'(N_PHASES - 1)) ? '0 : phase_reg + PH_W'(1);
        for (int k = N_PHASES - 1; k >= 1; k--) begin
            cand = int'(phase_reg) + k;
            if (cand >= N_PHASES) begin
                cand = cand - N_PHASES;
            end
            if (bus.demand[PH_W'(cand)]) begin
                rr_phase = PH_W'(cand);
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        timer_next      = timer_reg;
        blink_next      = blink_reg;
        from_flash_next = from_flash_reg;
        if (bus.tick) begin
            unique case (state_reg)
                S_GREEN: begin
                    if (timer_reg != '0) begin
                        if (bus.flash_en) begin
                            state_next = S_YELLOW;
                            timer_next = T_YELLOW;
                        end else begin
                            timer_next = timer_reg - TIMER_W'(1);
                        end
                    end else if (!bus.flash_en && (REST_IN_GREEN != 0) && !other_demand) begin
                        timer_next = '0;
                    end else begin
                        state_next = S_YELLOW;
                        timer_next = T_YELLOW;
                    end
                end
                S_YELLOW: begin
                    if (timer_reg != '0) begin
                        timer_next = timer_reg - TIMER_W'(1);
                    end else begin
                        state_next = S_ALLRED;
                        timer_next = T_ALLRED;
                    end
                end
                S_ALLRED: begin
                    if (timer_reg != '0) begin
                        timer_next = timer_reg - TIMER_W'(1);
                    end else if (bus.flash_en) begin
                        state_next      = S_FLASH;
                        timer_next      = '0;
                        blink_next      = 1'b0;
                        from_flash_next = 1'b0;
                    end else begin
                        // Recovery from flash always restarts the cycle at phase 0.
                        state_next      = S_GREEN;
                        phase_next      = from_flash_reg ? '0 : rr_phase;
                        timer_next      = T_GREEN;
                        from_flash_next = 1'b0;
                    end
                end
                S_FLASH: begin
                    timer_next = '0;
                    if (bus.flash_en) begin
                        blink_next = ~blink_reg;
                    end else begin
                        state_next      = S_ALLRED;
                        timer_next      = T_ALLRED;
                        blink_next      = 1'b0;
                        from_flash_next = 1'b1;
                    end
                end
                default: state_next = S_GREEN;
            endcase
        end
    end

    always_comb begin
        green_next  = '0;
        yellow_next = '0;
        red_next    = '1;
        unique case (state_next)
            S_GREEN: begin
                green_next = ONE_HOT0 << phase_next;
                red_next   = ~(ONE_HOT0 << phase_next);
            end
            S_YELLOW: begin
                yellow_next = ONE_HOT0 << phase_next;
                red_next    = ~(ONE_HOT0 << phase_next);
            end
            S_FLASH: begin
                yellow_next = {N_PHASES{blink_next}};
                red_next    = '0;
            end
            default: red_next = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_GREEN;
            phase_reg      <= '0;
            timer_reg      <= T_GREEN;
            blink_reg      <= 1'b0;
            from_flash_reg <= 1'b0;
            green_reg      <= ONE_HOT0;
            yellow_reg     <= '0;
            red_reg        <= ~ONE_HOT0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            timer_reg      <= timer_next;
            blink_reg      <= blink_next;
            from_flash_reg <= from_flash_next;
            green_reg      <= green_next;
            yellow_reg     <= yellow_next;
            red_reg        <= red_next;
        end
    end

    assign bus.green     = green_reg;
    assign bus.yellow    = yellow_reg;
    assign bus.red       = red_reg;
    assign bus.phase_idx = phase_reg;
    assign bus.state     = state_reg;
    assign bus.timer     = timer_reg;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: a rest-in-green unit driven by the
// step sequence, plus an always-cycle unit with no demand sharing tick and reset.
module tb_traffic_phase_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    traffic_phase_sequencer_if #(.N_PHASES(4), .TIMER_W(6)) bus_a ();
    traffic_phase_sequencer_if #(.N_PHASES(4), .TIMER_W(6)) bus_b ();

    traffic_phase_sequencer #(
        .N_PHASES(4), .TIMER_W(6), .GREEN_TIME(4), .YELLOW_TIME(2),
        .ALLRED_TIME(1), .REST_IN_GREEN(1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    traffic_phase_sequencer #(
        .N_PHASES(4), .TIMER_W(6), .GREEN_TIME(4), .YELLOW_TIME(2),
        .ALLRED_TIME(1), .REST_IN_GREEN(0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    assign bus_b.tick     = bus_a.tick;
    assign bus_b.demand   = 4'b0000;
    assign bus_b.flash_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] d);
        rst            = 1'b1;
        bus_a.tick     = 1'b1;
        bus_a.demand   = d;
        bus_a.flash_en = 1'b0;
        cyc(1);
        rst = 1'b0;
    endtask

    // Expected lamps follow directly from the expected state and phase.
    task automatic exp_all(input string tag, input int st, input int ph, input int tm);
        logic [3:0] g, y, r;
        g = 4'b0000;
        y = 4'b0000;
        r = 4'b1111;
        if (st == 0) begin
            g = 4'b0001 << ph;
            r = ~g;
        end else if (st == 1) begin
            y = 4'b0001 << ph;
            r = ~y;
        end
        chk({tag, ".state"},  bus_a.state, st);
        chk({tag, ".phase"},  bus_a.phase_idx, ph);
        chk({tag, ".timer"},  bus_a.timer, tm);
        chk({tag, ".green"},  bus_a.green, g);
        chk({tag, ".yellow"}, bus_a.yellow, y);
        chk({tag, ".red"},    bus_a.red, r);
    endtask

    task automatic exp_flash(input string tag, input logic [3:0] y);
        chk({tag, ".state"},  bus_a.state, 3);
        chk({tag, ".timer"},  bus_a.timer, 0);
        chk({tag, ".yellow"}, bus_a.yellow, y);
        chk({tag, ".green"},  bus_a.green, 4'b0000);
        chk({tag, ".red"},    bus_a.red, 4'b0000);
    endtask

    task automatic inv(input string tag, input logic [3:0] g, input logic [3:0] y,
                       input logic [3:0] r, input logic [1:0] st);
        checks++;
        assert ($onehot0(g) && ((g & y) == 4'b0) && ((g & r) == 4'b0) && ((y & r) == 4'b0)
                && ((st == 2'd3) || ((g | y | r) == 4'b1111))) else begin
            errors++;
            $error("FAIL %s: observed g=%b y=%b r=%b state=%0d expected exclusive lamps", tag, g, y, r, st);
        end
    endtask

    always @(negedge clk) begin
        inv("inv_a", bus_a.green, bus_a.yellow, bus_a.red, bus_a.state);
        inv("inv_b", bus_b.green, bus_b.yellow, bus_b.red, bus_b.state);
    end

    initial begin
        int off;
        int ph;
        checks = 0;
        errors = 0;

        // Round robin with full demand; the rest-free unit cycles identically with no demand.
        do_reset(4'b1111);
        exp_all("rr_reset", 0, 0, 3);
        for (int i = 1; i <= 28; i++) begin
            cyc(1);
            off = i % 7;
            ph  = (i / 7) % 4;
            if (off < 4)      exp_all("rr", 0, ph, 3 - off);
            else if (off < 6) exp_all("rr", 1, ph, 5 - off);
            else              exp_all("rr", 2, ph, 0);
            chk("rr_norest.phase", bus_b.phase_idx, ph);
            chk("rr_norest.timer", bus_b.timer, (off < 4) ? 3 - off : (off < 6) ? 5 - off : 0);
        end
        $display("round robin done: phase 0 re-entered at tick 28");

        // Skip phases 1 and 2.
        do_reset(4'b1001);
        cyc(6);
        exp_all("skip_allred0", 2, 0, 0);
        cyc(1);
        exp_all("skip_to3", 0, 3, 3);
        cyc(7);
        exp_all("skip_back0", 0, 0, 3);
        $display("skip done");

        // Rest in green, then demand on phase 2.
        do_reset(4'b0001);
        cyc(3);
        exp_all("rest_t0", 0, 0, 0);
        cyc(50);
        exp_all("rest_50", 0, 0, 0);
        bus_a.demand = 4'b0101;
        cyc(1);
        exp_all("rest_exit_y1", 1, 0, 1);
        cyc(1);
        exp_all("rest_exit_y0", 1, 0, 0);
        cyc(1);
        exp_all("rest_exit_ar", 2, 0, 0);
        cyc(1);
        exp_all("rest_to2", 0, 2, 3);
        $display("rest-in-green done");

        // Flash entry truncates green, toggles yellow, exits to phase 0.
        do_reset(4'b1111);
        cyc(1);
        exp_all("fl_pre", 0, 0, 2);
        bus_a.flash_en = 1'b1;
        cyc(1);
        exp_all("fl_y1", 1, 0, 1);
        cyc(1);
        exp_all("fl_y0", 1, 0, 0);
        cyc(1);
        exp_all("fl_ar", 2, 0, 0);
        cyc(1);
        exp_flash("fl_b0", 4'b0000);
        cyc(1);
        exp_flash("fl_b1", 4'b1111);
        cyc(1);
        exp_flash("fl_b2", 4'b0000);
        bus_a.flash_en = 1'b0;
        cyc(1);
        exp_all("fl_exit_ar", 2, 0, 0);
        cyc(1);
        exp_all("fl_exit_g0", 0, 0, 3);
        $display("flash done");

        // Tick gating mid-yellow.
        do_reset(4'b1111);
        cyc(4);
        exp_all("gate_pre", 1, 0, 1);
        bus_a.tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            exp_all("gate_hold", 1, 0, 1);
        end
        bus_a.tick = 1'b1;
        cyc(1);
        exp_all("gate_resume", 1, 0, 0);
        $display("tick gating done");

        // Reset with tick low during phase 2 all-red.
        do_reset(4'b1111);
        cyc(20);
        exp_all("rst_pre_ar2", 2, 2, 0);
        bus_a.tick = 1'b0;
        rst = 1'b1;
        cyc(1);
        exp_all("rst_mid", 0, 0, 3);
        rst = 1'b0;
        bus_a.tick = 1'b1;
        cyc(1);
        exp_all("rst_after", 0, 0, 2);
        $display("mid-operation reset done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
